// File: rtl/uart_rx_if.sv
// Byte delivery bus between the UART receiver and the register/FIFO block.
// Carries parityError only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] dataOut;
  logic                 dataValid;
  logic                 dataReady;
  logic                 frameError;
  logic                 overrun;
`ifdef UART_RX_PARITY_EN
  logic                 parityError;

  modport master (
    output dataOut, dataValid, frameError, overrun, parityError,
    input  dataReady
  );

  modport slave (
    input  dataOut, dataValid, frameError, overrun, parityError,
    output dataReady
  );
`else
  modport master (
    output dataOut, dataValid, frameError, overrun,
    input  dataReady
  );

  modport slave (
    input  dataOut, dataValid, frameError, overrun,
    output dataReady
  );
`endif
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver with start-glitch rejection, frame-error and overrun flags.
// Optional even-parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxIn,
  input  logic [DIV_WIDTH-1:0] divisor,
  uart_rx_if.master            rxBus,
  output logic                 busy
);

  localparam int SAMPLE_W = $clog2(OVERSAMPLE);
  localparam int BIT_W    = $clog2(DATA_BITS + 1);
  localparam logic [SAMPLE_W-1:0] HALF_LAST = SAMPLE_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMPLE_W-1:0] FULL_LAST = SAMPLE_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]    LAST_BIT  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rxState_t;

  rxState_t state, stateNext;

  logic [DIV_WIDTH-1:0] tickCnt;
  logic [DIV_WIDTH-1:0] divLatched;
  logic [SAMPLE_W-1:0]  sampleCnt;
  logic [BIT_W-1:0]     bitCnt;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 tick;
  logic                 startSeen;
  logic                 enterData;
  logic                 bitSample;
  logic                 frameDone;
  logic                 handshake;
  logic                 loadFrame;
  logic                 dropFrame;
`ifdef UART_RX_PARITY_EN
  logic                 parSample;
  logic                 parityBit;
`endif

  assign tick      = (state != IDLE) && (tickCnt == divLatched);
  assign busy      = (state != IDLE);
  assign handshake = rxBus.dataValid && rxBus.dataReady;
  assign loadFrame = frameDone && (!rxBus.dataValid || handshake);
  assign dropFrame = frameDone && rxBus.dataValid && !rxBus.dataReady;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Sampling points are all expressed as "last tick of a half or full bit period".
  always_comb begin
    stateNext = state;
    startSeen = 1'b0;
    enterData = 1'b0;
    bitSample = 1'b0;
    frameDone = 1'b0;
`ifdef UART_RX_PARITY_EN
    parSample = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rxIn) begin
          stateNext = START;
          startSeen = 1'b1;
        end
      end
      START: begin
        if (tick && sampleCnt == HALF_LAST) begin
          if (rxIn) begin
            stateNext = IDLE;
          end else begin
            stateNext = DATA;
            enterData = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick && sampleCnt == FULL_LAST) begin
          bitSample = 1'b1;
          if (bitCnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick && sampleCnt == FULL_LAST) begin
          parSample = 1'b1;
          stateNext = STOP;
        end
      end
`endif
      STOP: begin
        if (tick && sampleCnt == FULL_LAST) begin
          frameDone = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // sampleCnt wraps naturally at OVERSAMPLE, so it only needs clearing on entry to DATA.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tickCnt    <= '0;
      divLatched <= '0;
      sampleCnt  <= '0;
      bitCnt     <= '0;
    end else begin
      if (startSeen) begin
        divLatched <= divisor;
      end
      if (state == IDLE || tick) begin
        tickCnt <= '0;
      end else begin
        tickCnt <= tickCnt + DIV_WIDTH'(1);
      end
      if (state == IDLE || enterData) begin
        sampleCnt <= '0;
      end else if (tick) begin
        sampleCnt <= sampleCnt + SAMPLE_W'(1);
      end
      if (state == IDLE) begin
        bitCnt <= '0;
      end else if (bitSample) begin
        bitCnt <= bitCnt + BIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shiftReg <= '0;
    end else if (bitSample) begin
      shiftReg <= {rxIn, shiftReg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      parityBit <= 1'b0;
    end else if (parSample) begin
      parityBit <= rxIn;
    end
  end
`endif

  // A frame landing on a handshake cycle replaces the old byte, so dataValid never drops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rxBus.dataOut    <= '0;
      rxBus.dataValid  <= 1'b0;
      rxBus.frameError <= 1'b0;
      rxBus.overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rxBus.parityError <= 1'b0;
`endif
    end else begin
      if (loadFrame) begin
        rxBus.dataOut    <= shiftReg;
        rxBus.frameError <= ~rxIn;
        rxBus.dataValid  <= 1'b1;
`ifdef UART_RX_PARITY_EN
        rxBus.parityError <= (^shiftReg) ^ parityBit;
`endif
      end else if (handshake) begin
        rxBus.dataValid <= 1'b0;
      end
      if (dropFrame) begin
        rxBus.overrun <= 1'b1;
      end else if (handshake) begin
        rxBus.overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected bytes, a monitor pops them on handshakes.
// Build with UART_RX_PARITY_EN defined to exercise the parity path.
module tb_uart_rx;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int DIV_WIDTH  = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_TICKS = 168;
`else
  localparam int FRAME_TICKS = 152;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } expT;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 rxIn = 1'b0;
  logic [DIV_WIDTH-1:0] divisor = 16'd5;
  logic                 busy;

  expT expQ[$];
  int  testsRun = 0;
  int  failCount = 0;

  uart_rx_if #(.DATA_BITS(DATA_BITS)) rxBus ();

  uart_rx #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE),
    .DIV_WIDTH (DIV_WIDTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rxIn   (rxIn),
    .divisor(divisor),
    .rxBus  (rxBus),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one frame starting at the current negedge; bit length follows the current divisor.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parityBit,
                               input logic expectLoad, input logic expFe, input logic expPe);
    int bitLen;
    expT e;
    bitLen = OVERSAMPLE * (int'(divisor) + 1);
    if (expectLoad) begin
      e.data = data;
      e.fe   = expFe;
      e.pe   = expPe;
      expQ.push_back(e);
    end
    rxIn = 1'b0;
    repeat (bitLen) @(negedge clk);
    for (int i = 0; i < DATA_BITS; i++) begin
      rxIn = data[i];
      repeat (bitLen) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxIn = parityBit;
    repeat (bitLen) @(negedge clk);
`endif
    rxIn = stopBit;
    repeat (bitLen) @(negedge clk);
    rxIn = 1'b1;
  endtask

  task automatic pulseReady();
    rxBus.dataReady = 1'b1;
    @(negedge clk);
    rxBus.dataReady = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkRise(input string name, input int cycles);
    repeat (cycles) @(negedge clk);
    checkOutput({name, "_early"}, rxBus.dataValid, 0);
    @(negedge clk);
    checkOutput({name, "_rise"}, rxBus.dataValid, 1);
  endtask

  // Monitor: looks just before each rising edge so it sees exactly what the handshake sees.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      #2;
      if (reset === 1'b1 && rxBus.dataValid === 1'b1 && rxBus.dataReady === 1'b1) begin
        testsRun++;
        if (expQ.size() == 0) begin
          failCount++;
          $display("[TB] FAIL sb_unexpected: got byte 0x%0h, expected none", rxBus.dataOut);
        end else begin
          e = expQ.pop_front();
          if (rxBus.dataOut !== e.data || rxBus.frameError !== e.fe) begin
            failCount++;
            $display("[TB] FAIL sb_frame: got data 0x%0h fe %0b, expected data 0x%0h fe %0b",
                     rxBus.dataOut, rxBus.frameError, e.data, e.fe);
          end
`ifdef UART_RX_PARITY_EN
          checkOutput("sb_parityError", rxBus.parityError, e.pe);
`endif
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rxBus.dataReady = 1'b0;

    // Reset with the line low: nothing may start.
    repeat (2) @(negedge clk);
    checkOutput("rst_dataOut", rxBus.dataOut, 0);
    checkOutput("rst_dataValid", rxBus.dataValid, 0);
    checkOutput("rst_frameError", rxBus.frameError, 0);
    checkOutput("rst_overrun", rxBus.overrun, 0);
    checkOutput("rst_busy", busy, 0);
    rxIn = 1'b1;
    reset = 1'b1;
    divisor = 16'd0;
    idle(2);
    checkOutput("rst_release_busy", busy, 0);

    // 0xA5, good stop, exact rise time then hold and handshake.
    fork
      applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkRise("a5", FRAME_TICKS);
    join
    checkOutput("a5_dataOut", rxBus.dataOut, 8'hA5);
    checkOutput("a5_frameError", rxBus.frameError, 0);
    idle(20);
    checkOutput("a5_hold", rxBus.dataValid, 1);
    pulseReady();
    checkOutput("a5_clear", rxBus.dataValid, 0);
    idle(10);

    // Start glitch of 4 cycles is rejected at tick 8.
    rxIn = 1'b0;
    @(negedge clk);
    checkOutput("glitch_busy_start", busy, 1);
    idle(3);
    rxIn = 1'b1;
    idle(4);
    checkOutput("glitch_busy_tick8", busy, 1);
    @(negedge clk);
    checkOutput("glitch_busy_idle", busy, 0);
    checkOutput("glitch_dataValid", rxBus.dataValid, 0);
    checkOutput("glitch_overrun", rxBus.overrun, 0);
    idle(10);

    // 0x3C with a zero stop bit.
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(40);
    checkOutput("fe_dataValid", rxBus.dataValid, 1);
    checkOutput("fe_dataOut", rxBus.dataOut, 8'h3C);
    checkOutput("fe_frameError", rxBus.frameError, 1);
    checkOutput("fe_overrun", rxBus.overrun, 0);
    pulseReady();
    checkOutput("fe_clear", rxBus.dataValid, 0);
    idle(10);

    // Back-to-back frames with no consumer: the second is dropped.
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(5);
    checkOutput("ovr_dataOut", rxBus.dataOut, 8'h11);
    checkOutput("ovr_overrun", rxBus.overrun, 1);
    checkOutput("ovr_dataValid", rxBus.dataValid, 1);
    pulseReady();
    checkOutput("ovr_clear_valid", rxBus.dataValid, 0);
    checkOutput("ovr_clear_overrun", rxBus.overrun, 0);
    idle(10);

    // Handshake in the same cycle a new frame completes: valid stays high, no overrun.
    applyStimulus(8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    fork
      applyStimulus(8'hF0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      begin
        idle(FRAME_TICKS);
        pulseReady();
        checkOutput("reload_valid", rxBus.dataValid, 1);
      end
    join
    checkOutput("reload_dataOut", rxBus.dataOut, 8'hF0);
    checkOutput("reload_overrun", rxBus.overrun, 0);
    pulseReady();
    idle(10);

    // Reset in the middle of a frame drops it silently.
    rxIn = 1'b0;
    idle(40);
    reset = 1'b0;
    rxIn = 1'b1;
    idle(2);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_dataValid", rxBus.dataValid, 0);
    checkOutput("midrst_overrun", rxBus.overrun, 0);
    reset = 1'b1;
    idle(10);

    // Slower divisor: 4 clocks per tick.
    divisor = 16'd3;
    @(negedge clk);
    fork
      applyStimulus(8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkRise("div3", FRAME_TICKS * 4);
    join
    checkOutput("div3_dataOut", rxBus.dataOut, 8'h80);
    pulseReady();
    idle(10);

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit for 0x80.
    fork
      applyStimulus(8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      checkRise("par", FRAME_TICKS * 4);
    join
    checkOutput("par_parityError", rxBus.parityError, 1);
    pulseReady();
    idle(10);
`endif

    checkOutput("sb_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver that consumes the already-synchronized RX line, i.e. the output of the two-stage input synchronizer, and delivers bytes over a valid/ready interface to the peripheral bus register block.
- 16x oversampling with a runtime divisor.
- Start-bit glitch rejection.
- Frame-error and overrun reporting.
- Sits between the pin synchronizer and the UART MMIO/FIFO logic.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first.
OVERSAMPLE, 16, ticks per bit; must be an even power of two, minimum 4.
DIV_WIDTH, 16, width of the divisor port.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-low reset (0 = reset).
rxIn  in  1  synchronized serial line; idle = 1.
divisor  in  DIV_WIDTH  clock cycles per oversample tick minus 1; latched at start detection.
dataOut  out  DATA_BITS  received byte.
dataValid  out  1  dataOut/frameError hold a received frame.
dataReady  in  1  consumer accepts; handshake = dataValid & dataReady.
frameError  out  1  stop bit of the frame in dataOut was 0; meaningful only while dataValid.
overrun  out  1  sticky; a frame was discarded because dataValid was held.
busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (reset=0 at a clk edge), from any state including mid-frame:
  - state=IDLE; all counters 0.
  - dataOut=0, dataValid=0, frameError=0, overrun=0, busy=0.
  - A partial frame is dropped with no flags.
- Tick generator:
  - Counter is held at 0 in IDLE.
  - Otherwise it counts 0..divLatched, asserts tick when equal to divLatched, then wraps to 0.
  - divisor=0 gives a tick every cycle.
  - If the start is detected at cycle c, tick k occurs at cycle c + k*(divLatched+1).
- FSM states:
  - IDLE → START when rxIn==0. divLatched=divisor; sampleCnt=0.
  - START: on each tick sampleCnt++. At tick OVERSAMPLE/2 (mid start bit) sample rxIn:
    - rxIn==0 → DATA, with sampleCnt=0 and bitCnt=0.
    - rxIn==1 → IDLE (glitch rejected; no outputs change).
  - DATA: on every OVERSAMPLE-th tick, shift rxIn into the MSB of the shift register (right shift, LSB first) and increment bitCnt. After DATA_BITS samples → STOP.
  - STOP: at the OVERSAMPLE-th tick sample rxIn. Frame complete; → IDLE in the same cycle.
- Frame completion at tick T = OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+1) (152 with defaults):
  - If dataValid==0, or a handshake occurs in the same cycle:
    - dataOut ← shift register.
    - frameError ← ~stopSample.
    - dataValid=1 from the next cycle.
  - If dataValid==1 and no handshake this cycle: the new frame is discarded, overrun=1, and dataOut/frameError are kept.
- Handshake clears dataValid the next cycle, unless a new frame loads in the same cycle, in which case dataValid stays 1.
- overrun clears on reset or on a handshake cycle; a simultaneous set wins.
- Break (rxIn held 0): each frame time produces dataOut=0 with frameError=1. This is intended.
- busy=1 from the cycle after start detection until the cycle after the glitch reject or the stop sample.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - PARITY state inserted between DATA and STOP; the parity bit is sampled at its OVERSAMPLE-th tick.
  - Even parity: the error condition is XOR(data, parityBit) != 0.
  - Extra output port parityError (1 bit). It is reset to 0, loaded alongside frameError, and follows the same overrun/keep rules.
  - T grows by OVERSAMPLE (168 with defaults).
- Undefined: no PARITY state, no parityError port, frame timing as above.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with rxIn=0, divisor=5 → dataOut=0, dataValid=0, frameError=0, overrun=0, busy=0; no start detected while in reset.
2. divisor=0, send 0xA5 with a valid stop bit (16 cycles/bit), dataReady=0 → dataValid rises at c+153 with dataOut=0xA5, frameError=0, and holds. Pulse dataReady=1 for one cycle → dataValid=0 on the next cycle.
3. Glitch: divisor=0, rxIn=0 for 4 cycles then 1 → busy=1 through tick 8, back to IDLE at c+9; dataValid stays 0, no flags.
4. divisor=0, send 0x3C with stop bit 0 → dataValid=1, dataOut=0x3C, frameError=1, overrun=0.
5. Overrun: send 0x11 then 0x22 back-to-back with dataReady=0 → dataOut=0x11, overrun=1 after the second stop. One handshake → dataValid=0, overrun=0.
6. divisor=3, send 0x80 → dataValid rises at c+152*4+1 = c+609, dataOut=0x80. With UART_RX_PARITY_EN and a wrong parity bit → parityError=1 at c+168*4+1.
